iomem_ctrl: RTL and testbench
=============================

# iomem_ctrl

Peripheral-bus controller between the picosoc `iomem_*` master port and up to `NUM_SLAVES` memory-mapped peripherals, such as GPIO and future USB-UART registers. It decodes the address page and forwards each CPU transaction to exactly one slave. It then waits for that slave's ready, returns its read data with a single-cycle `iomem_ready`, and terminates unmapped or hung accesses with an error word so the CPU never stalls.

## Interface
Parameters:
- `NUM_SLAVES`, 4 — number of slave ports (1..8).
- `BASE_PAGE`, 8'h03 — `iomem_addr[31:24]` of slave 0; slave i owns page `BASE_PAGE+i`.
- `TIMEOUT`, 255 — maximum cycles to wait for slave ready (1..255).
- `ERR_DATA`, 32'hDEAD_BEEF — `iomem_rdata` returned on decode error or timeout.

Ports:
- `clk` in 1 — clock clk.
- `resetn` in 1 — reset resetn, synchronous, active-low.
- `iomem_valid` in 1 — CPU request.
- `iomem_wstrb` in 4 — byte write strobes; 0 means read.
- `iomem_addr` in 32 — CPU address.
- `iomem_wdata` in 32 — CPU write data.
- `iomem_ready` out 1 — one-cycle completion pulse.
- `iomem_rdata` out 32 — read data, valid while `iomem_ready`=1.
- `s_valid` out NUM_SLAVES — one-hot slave request.
- `s_addr` out 32 — registered copy of `iomem_addr`.
- `s_wstrb` out 4 — registered copy of `iomem_wstrb`.
- `s_wdata` out 32 — registered copy of `iomem_wdata`.
- `s_ready` in NUM_SLAVES — slave completion, one bit per slave.
- `s_rdata` in 32*NUM_SLAVES — slave i read data in bits [32i+31:32i].
- `err_clear` in 1 — clears `err_count`.
- `err_count` out 8 — saturating count of decode errors plus timeouts.
- `err_addr` out 32 — address of the most recent error.

## Operation
- FSM states are IDLE, ACCESS and RESP.
- **IDLE:**
  - If `iomem_valid`=1, register addr/wstrb/wdata into `s_*`.
  - Compute `idx = iomem_addr[31:24] - BASE_PAGE` in 8-bit wrapping arithmetic.
  - If `idx < NUM_SLAVES`: set `s_valid[idx]`=1, clear the timeout counter, go to ACCESS.
  - Otherwise (decode error): load `iomem_rdata`=ERR_DATA, record the error, go to RESP.
- **ACCESS:**
  - Only the selected bit of `s_ready` is sampled; ready from unselected slaves is ignored.
  - On selected `s_ready`=1: capture its `s_rdata` slice into `iomem_rdata`, clear `s_valid`, go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 with no ready: clear `s_valid`, load ERR_DATA, record the error, go to RESP.
  - Ready and timeout in the same cycle: ready wins and no error is recorded.
- **RESP:** `iomem_ready`=1 for exactly this cycle, then go to IDLE.
- Writes are forwarded unchanged. A write that ends in a decode error or timeout has no side effect beyond the error record.
- **Record error:**
  - `err_addr` is set to the offending address.
  - `err_count` increments and saturates at 255.
  - `err_clear` alone sets `err_count` to 0.
  - `err_clear` together with an error sets `err_count` to 1.
- `iomem_rdata` holds its last value outside RESP.

## Timing
- All outputs are registered.
- Reset values: `iomem_ready`=0, `iomem_rdata`=0, `s_valid`=0, `s_addr`=0, `s_wstrb`=0, `s_wdata`=0, `err_count`=0, `err_addr`=0. The FSM resets to IDLE.
- A request accepted in IDLE at cycle T asserts `s_valid` at T+1.
- Selected `s_ready` high at cycle T+k (k≥1) gives `iomem_ready` at T+k+1. Minimum latency from request to ready is 2 cycles.
- A decode error gives `iomem_ready` at T+1.
- A timeout gives `iomem_ready` at T+TIMEOUT+1. `s_valid` is high for exactly TIMEOUT cycles.
- `s_valid` drops in the cycle after ready is sampled, so each slave sees at most one ready per request.
- After RESP the controller returns to IDLE. The CPU deasserts `iomem_valid` in that cycle, so no duplicate request is issued.
- A back-to-back request is accepted in the first IDLE cycle in which `iomem_valid`=1.
- A reset asserted mid-transaction forces all outputs to their reset values at the next edge. A pending slave access is abandoned with no `iomem_ready`.

## Test plan
- **Read slave 1:** addr 0x0400_0000, wstrb 0, slave 1 ready at T+1 with 0x1234_5678 -> `s_valid`=4'b0010 for 1 cycle; `iomem_ready` at T+2 with rdata 0x1234_5678.
- **Byte write slave 0:** addr 0x0300_0004, wstrb 4'b0001, wdata 0xA5 -> `s_wstrb`=1, `s_wdata`=0xA5, `s_addr`=0x0300_0004; one `iomem_ready`; `err_count`=0.
- **Unmapped read:** addr 0x0900_0000 and then 0x0200_0000 -> each gives `iomem_ready` at T+1 with 0xDEAD_BEEF and no `s_valid`; `err_count`=2, `err_addr`=0x0200_0000.
- **Timeout:** slave 2 never ready, TIMEOUT=255 -> `s_valid[2]` high for 255 cycles; ready at T+256 with 0xDEAD_BEEF; `err_count`+1.
- **Ready at the timeout boundary:** slave ready in the cycle the counter reaches TIMEOUT-1 -> slave data returned, no error recorded. Stray `s_ready[3]` during a slave 0 access -> ignored.
- **Reset and counter edge cases:** reset asserted while in ACCESS -> `s_valid`=0 and no `iomem_ready`. 260 errors -> `err_count`=255. `err_clear` together with an error -> `err_count`=1.

Source files
------------

// File: rtl/iomem_ctrl.sv
`timescale 1ns/1ps
// iomem_ctrl: bridges the picosoc iomem master port to NUM_SLAVES
// memory-mapped peripherals. One 16 MB page per slave starting at BASE_PAGE.
// Unmapped pages and slaves that never answer are terminated with ERR_DATA,
// so the CPU always sees exactly one iomem_ready per request.
//
// Handshake: the CPU holds iomem_valid until it sees the one-cycle
// iomem_ready pulse; a slave sees s_valid high (one-hot) until the controller
// samples its own s_ready bit high or the wait budget of TIMEOUT cycles runs
// out, after which s_valid drops so a slave never sees a second request.
module iomem_ctrl #(
   parameter int unsigned NUM_SLAVES = 4,
   parameter logic [7:0]  BASE_PAGE  = 8'h03,
   parameter int unsigned TIMEOUT    = 255,
   parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       iomem_valid,
   input  logic [3:0]                 iomem_wstrb,
   input  logic [31:0]                iomem_addr,
   input  logic [31:0]                iomem_wdata,
   output logic                       iomem_ready,
   output logic [31:0]                iomem_rdata,
   output logic [NUM_SLAVES-1:0]      s_valid,
   output logic [31:0]                s_addr,
   output logic [3:0]                 s_wstrb,
   output logic [31:0]                s_wdata,
   input  logic [NUM_SLAVES-1:0]      s_ready,
   input  logic [32*NUM_SLAVES-1:0]   s_rdata,
   input  logic                       err_clear,
   output logic [7:0]                 err_count,
   output logic [31:0]                err_addr,
   output logic [1:0]                 dbg_state_o
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [7:0]              cnt_q, cnt_d;
   logic [NUM_SLAVES-1:0]   s_valid_q, s_valid_d;
   logic [31:0]             s_addr_q, s_addr_d;
   logic [3:0]              s_wstrb_q, s_wstrb_d;
   logic [31:0]             s_wdata_q, s_wdata_d;
   logic                    ready_q, ready_d;
   logic [31:0]             rdata_q, rdata_d;
   logic [7:0]              err_count_q, err_count_d;
   logic [31:0]             err_addr_q, err_addr_d;

   // Decode and selection helpers
   logic [7:0]              idx;
   logic                    hit;
   logic [NUM_SLAVES-1:0]   dec_onehot;
   logic                    sel_ready;
   logic [31:0]             sel_rdata;
   logic                    err_ev;
   logic [31:0]             err_src;

   // Page decode: 8-bit wrapping subtraction so pages below BASE_PAGE land
   // far above NUM_SLAVES and fall out as decode errors.
   always_comb begin
      idx        = iomem_addr[31:24] - BASE_PAGE;
      hit        = (idx < 8'(NUM_SLAVES));
      dec_onehot = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         dec_onehot[i] = (idx == 8'(i));
      end
   end

   // The registered one-hot s_valid doubles as the slave select, so ready
   // and data from any slave that was not addressed are masked away.
   always_comb begin
      sel_ready = |(s_ready & s_valid_q);
      sel_rdata = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (s_valid_q[i]) begin
            sel_rdata = sel_rdata | s_rdata[32*i +: 32];
         end
      end
   end

   // Next-state and datapath: IDLE accepts, ACCESS waits for the slave or
   // the timeout, RESP is the single cycle carrying iomem_ready.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      s_valid_d = s_valid_q;
      s_addr_d  = s_addr_q;
      s_wstrb_d = s_wstrb_q;
      s_wdata_d = s_wdata_q;
      rdata_d   = rdata_q;
      ready_d   = 1'b0;
      err_ev    = 1'b0;
      err_src   = s_addr_q;

      case (state_q)
         ST_IDLE: begin
            if (iomem_valid) begin
               s_addr_d  = iomem_addr;
               s_wstrb_d = iomem_wstrb;
               s_wdata_d = iomem_wdata;
               if (hit) begin
                  s_valid_d = dec_onehot;
                  cnt_d     = '0;
                  state_d   = ST_ACCESS;
               end else begin
                  rdata_d = ERR_DATA;
                  err_ev  = 1'b1;
                  err_src = iomem_addr;
                  ready_d = 1'b1;
                  state_d = ST_RESP;
               end
            end
         end
         ST_ACCESS: begin
            // Ready is checked first so a reply in the last allowed cycle
            // still completes normally.
            if (sel_ready) begin
               rdata_d   = sel_rdata;
               s_valid_d = '0;
               ready_d   = 1'b1;
               state_d   = ST_RESP;
            end else if (cnt_q == 8'(TIMEOUT - 1)) begin
               rdata_d   = ERR_DATA;
               s_valid_d = '0;
               err_ev    = 1'b1;
               ready_d   = 1'b1;
               state_d   = ST_RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            s_valid_d = '0;
            state_d   = ST_IDLE;
         end
      endcase
   end

   // Error record: clear alone zeroes the count, an error wins over a clear
   // by restarting at one, otherwise the count saturates at 255.
   always_comb begin
      err_count_d = err_count_q;
      err_addr_d  = err_addr_q;
      if (err_ev) begin
         err_addr_d = err_src;
         if (err_clear) begin
            err_count_d = 8'd1;
         end else if (err_count_q != 8'hFF) begin
            err_count_d = err_count_q + 8'd1;
         end
      end else if (err_clear) begin
         err_count_d = 8'd0;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt_q       <= '0;
         s_valid_q   <= '0;
         s_addr_q    <= '0;
         s_wstrb_q   <= '0;
         s_wdata_q   <= '0;
         ready_q     <= 1'b0;
         rdata_q     <= '0;
         err_count_q <= '0;
         err_addr_q  <= '0;
      end else begin
         cnt_q       <= cnt_d;
         s_valid_q   <= s_valid_d;
         s_addr_q    <= s_addr_d;
         s_wstrb_q   <= s_wstrb_d;
         s_wdata_q   <= s_wdata_d;
         ready_q     <= ready_d;
         rdata_q     <= rdata_d;
         err_count_q <= err_count_d;
         err_addr_q  <= err_addr_d;
      end
   end

   assign iomem_ready = ready_q;
   assign iomem_rdata = rdata_q;
   assign s_valid     = s_valid_q;
   assign s_addr      = s_addr_q;
   assign s_wstrb     = s_wstrb_q;
   assign s_wdata     = s_wdata_q;
   assign err_count   = err_count_q;
   assign err_addr    = err_addr_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_iomem_ctrl.sv
`timescale 1ns/1ps
// Bench for iomem_ctrl: directed table of transactions with hand-computed
// expectations, randomized transactions predicted by a page/latency model,
// and hand-written sequences for error-count clear, saturation and reset.
module tb_iomem_ctrl;
   localparam int          NS  = 4;
   localparam int          TO  = 255;
   localparam logic [31:0] ERR = 32'hDEAD_BEEF;

   logic              clk = 1'b0;
   logic              resetn;
   logic              iomem_valid;
   logic [3:0]        iomem_wstrb;
   logic [31:0]       iomem_addr;
   logic [31:0]       iomem_wdata;
   logic              iomem_ready;
   logic [31:0]       iomem_rdata;
   logic [NS-1:0]     s_valid;
   logic [31:0]       s_addr;
   logic [3:0]        s_wstrb;
   logic [31:0]       s_wdata;
   logic [NS-1:0]     s_ready;
   logic [32*NS-1:0]  s_rdata;
   logic              err_clear;
   logic [7:0]        err_count;
   logic [31:0]       err_addr;
   logic [1:0]        dbg_state;

   int          n_checks = 0;
   int          n_errors = 0;
   int          m_cnt    = 0;
   logic [31:0] m_addr   = '0;

   typedef struct {
      logic [31:0]      addr;
      logic [3:0]       wstrb;
      logic [31:0]      wdata;
      int               delay;   // cycle (1..) the target raises ready, 0 = never
      logic [NS-1:0]    stray;   // ready bits driven on non-target slaves
      logic [32*NS-1:0] sdata;
      bit               clr;     // err_clear in the accept cycle
      int               lat;     // cycles from accept to iomem_ready
      logic [31:0]      rd;
      logic [NS-1:0]    mask;
      int               svc;     // cycles s_valid is high
      int               cnt;     // err_count afterwards
      logic [31:0]      eaddr;   // err_addr afterwards
   } vec_t;

   iomem_ctrl #(
      .NUM_SLAVES (NS),
      .BASE_PAGE  (8'h03),
      .TIMEOUT    (TO),
      .ERR_DATA   (ERR)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .iomem_valid (iomem_valid),
      .iomem_wstrb (iomem_wstrb),
      .iomem_addr  (iomem_addr),
      .iomem_wdata (iomem_wdata),
      .iomem_ready (iomem_ready),
      .iomem_rdata (iomem_rdata),
      .s_valid     (s_valid),
      .s_addr      (s_addr),
      .s_wstrb     (s_wstrb),
      .s_wdata     (s_wdata),
      .s_ready     (s_ready),
      .s_rdata     (s_rdata),
      .err_clear   (err_clear),
      .err_count   (err_count),
      .err_addr    (err_addr),
      .dbg_state_o (dbg_state)
   );

   // Clock
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] addr, input logic [3:0] wstrb,
                               input logic [31:0] wdata, input int delay,
                               input logic [NS-1:0] stray, input logic [32*NS-1:0] sdata,
                               input int lat, input logic [31:0] rd, input logic [NS-1:0] mask,
                               input int svc, input int cnt, input logic [31:0] eaddr);
      vec_t v;
      v.addr = addr; v.wstrb = wstrb; v.wdata = wdata; v.delay = delay;
      v.stray = stray; v.sdata = sdata; v.clr = 1'b0; v.lat = lat; v.rd = rd;
      v.mask = mask; v.svc = svc; v.cnt = cnt; v.eaddr = eaddr;
      return v;
   endfunction

   // Reference model: page arithmetic decides the slave, the slave's reply
   // delay decides latency or timeout, errors feed a saturating counter.
   function automatic vec_t predict(input logic [31:0] addr, input logic [3:0] wstrb,
                                    input logic [31:0] wdata, input int delay,
                                    input logic [NS-1:0] stray, input logic [32*NS-1:0] sdata,
                                    input bit clr);
      vec_t v;
      int   idx;
      bit   err;
      v.addr = addr; v.wstrb = wstrb; v.wdata = wdata; v.delay = delay;
      v.sdata = sdata; v.clr = clr;
      idx = int'(addr[31:24]) - 3;
      if (idx < 0) idx += 256;
      if (idx >= NS) begin
         v.lat = 1; v.rd = ERR; v.mask = '0; v.svc = 0; err = 1'b1;
      end else if (delay >= 1 && delay <= TO) begin
         v.lat = delay + 1; v.rd = sdata[32*idx +: 32]; v.mask = NS'(1) << idx;
         v.svc = delay; err = 1'b0;
      end else begin
         v.lat = TO + 1; v.rd = ERR; v.mask = NS'(1) << idx; v.svc = TO; err = 1'b1;
      end
      v.stray = stray & ~v.mask;
      if (err) begin
         m_cnt  = clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
         m_addr = addr;
      end else if (clr) begin
         m_cnt = 0;
      end
      v.cnt   = m_cnt;
      v.eaddr = m_addr;
      return v;
   endfunction

   // Drives one CPU request, plays the slave, and checks the whole exchange.
   task automatic run_txn(input vec_t v);
      int          got;
      int          svc;
      int          bad;
      logic [31:0] rd;
      @(negedge clk);
      iomem_valid = 1'b1;
      iomem_addr  = v.addr;
      iomem_wstrb = v.wstrb;
      iomem_wdata = v.wdata;
      err_clear   = v.clr;
      s_rdata     = v.sdata;
      s_ready     = '0;
      @(negedge clk);
      iomem_valid = 1'b0;
      err_clear   = 1'b0;
      iomem_addr  = $urandom;
      iomem_wdata = $urandom;
      iomem_wstrb = 4'($urandom);
      check("s_addr", s_addr, v.addr);
      check("s_wstrb", 32'(s_wstrb), 32'(v.wstrb));
      check("s_wdata", s_wdata, v.wdata);
      got = 0; svc = 0; bad = 0; rd = '0;
      for (int c = 1; c <= TO + 40; c++) begin
         if (s_valid != '0) begin
            svc++;
            if (s_valid != v.mask) bad++;
         end
         if (iomem_ready) begin
            got = c;
            rd  = iomem_rdata;
            s_ready = '0;
            break;
         end
         s_ready = v.stray;
         if (c == v.delay) s_ready = s_ready | v.mask;
         @(negedge clk);
      end
      s_ready = '0;
      if (got == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL latency: no iomem_ready within %0d cycles (addr %h)", TO + 40, v.addr);
      end else begin
         check("latency", got, v.lat);
         check("rdata", rd, v.rd);
      end
      check("s_valid_cycles", svc, v.svc);
      check("s_valid_onehot_errs", bad, 0);
      @(negedge clk);
      check("ready_pulse_width", 32'(iomem_ready), 32'd0);
      check("err_count", 32'(err_count), 32'(v.cnt));
      check("err_addr", err_addr, v.eaddr);
   endtask

   initial begin
      vec_t tbl[10];
      vec_t v;
      int   pulses;

      // Reset with a request presented, which must be ignored
      resetn      = 1'b0;
      iomem_valid = 1'b1;
      iomem_addr  = 32'h0400_0000;
      iomem_wstrb = 4'hF;
      iomem_wdata = 32'h1234_5678;
      s_ready     = '0;
      s_rdata     = '0;
      err_clear   = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_iomem_ready", 32'(iomem_ready), 32'd0);
      check("rst_iomem_rdata", iomem_rdata, 32'd0);
      check("rst_s_valid", 32'(s_valid), 32'd0);
      check("rst_s_addr", s_addr, 32'd0);
      check("rst_s_wstrb", 32'(s_wstrb), 32'd0);
      check("rst_s_wdata", s_wdata, 32'd0);
      check("rst_err_count", 32'(err_count), 32'd0);
      check("rst_err_addr", err_addr, 32'd0);
      iomem_valid = 1'b0;
      resetn      = 1'b1;

      // Directed table: sdata packs {slave3, slave2, slave1, slave0}
      tbl[0] = mk(32'h0400_0000, 4'h0, 32'h0, 1, 4'h0, {32'h0, 32'h0, 32'h1234_5678, 32'h0},
                  2, 32'h1234_5678, 4'b0010, 1, 0, 32'h0);
      tbl[1] = mk(32'h0300_0004, 4'h1, 32'hA5, 2, 4'h0, {32'h0, 32'h0, 32'h0, 32'h5555_AAAA},
                  3, 32'h5555_AAAA, 4'b0001, 2, 0, 32'h0);
      tbl[2] = mk(32'h0900_0000, 4'h0, 32'h0, 1, 4'h0, {4{32'h1111_1111}},
                  1, ERR, 4'b0000, 0, 1, 32'h0900_0000);
      tbl[3] = mk(32'h0200_0000, 4'h0, 32'h0, 1, 4'h0, {4{32'h2222_2222}},
                  1, ERR, 4'b0000, 0, 2, 32'h0200_0000);
      tbl[4] = mk(32'h0500_0010, 4'h0, 32'h0, 0, 4'h0, {32'h0, 32'h7777_7777, 64'h0},
                  256, ERR, 4'b0100, 255, 3, 32'h0500_0010);
      tbl[5] = mk(32'h0600_0000, 4'h0, 32'h0, 255, 4'h0, {32'hCAFE_F00D, 96'h0},
                  256, 32'hCAFE_F00D, 4'b1000, 255, 3, 32'h0500_0010);
      tbl[6] = mk(32'h0300_0100, 4'h0, 32'h0, 3, 4'b1000, {32'h9999_9999, 64'h0, 32'h1111_2222},
                  4, 32'h1111_2222, 4'b0001, 3, 3, 32'h0500_0010);
      tbl[7] = mk(32'h0700_0000, 4'hF, 32'h12, 1, 4'h0, {4{32'h3333_3333}},
                  1, ERR, 4'b0000, 0, 4, 32'h0700_0000);
      tbl[8] = mk(32'hFF00_0000, 4'h0, 32'h0, 1, 4'h0, '0,
                  1, ERR, 4'b0000, 0, 5, 32'hFF00_0000);
      tbl[9] = mk(32'h0400_0008, 4'hC, 32'hFEED_0000, 0, 4'h0, {4{32'h4444_4444}},
                  256, ERR, 4'b0010, 255, 6, 32'h0400_0008);
      for (int i = 0; i < 10; i++) begin
         v = predict(tbl[i].addr, tbl[i].wstrb, tbl[i].wdata, tbl[i].delay,
                     tbl[i].stray, tbl[i].sdata, 1'b0);
         run_txn(tbl[i]);
      end

      // err_clear in the same cycle as a decode error restarts the count at 1
      v = predict(32'h0800_0000, 4'h0, 32'h0, 1, '0, '0, 1'b1);
      check("model_clr_with_err", 32'(v.cnt), 32'd1);
      run_txn(v);

      // err_clear alone zeroes the count
      @(negedge clk);
      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
      m_cnt     = 0;
      check("err_clear_alone", 32'(err_count), 32'd0);

      // Randomized transactions against the model
      for (int n = 0; n < 40; n++) begin
         logic [31:0]      a;
         logic [32*NS-1:0] sd;
         int               d;
         a  = {8'(8'h01 + 8'($urandom_range(0, 7))), 24'($urandom)};
         sd = {$urandom, $urandom, $urandom, $urandom};
         d  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
         v  = predict(a, 4'($urandom), $urandom, d, NS'($urandom), sd,
                      ($urandom_range(0, 7) == 0));
         run_txn(v);
      end

      // 260 decode errors saturate the counter
      for (int n = 0; n < 260; n++) begin
         v = predict({8'h10 + 8'($urandom_range(0, 200)), 24'($urandom)}, 4'h0, 32'h0, 1, '0, '0, 1'b0);
         run_txn(v);
      end
      check("err_count_saturated", 32'(err_count), 32'd255);

      // Reset while a slave access is pending
      @(negedge clk);
      iomem_valid = 1'b1;
      iomem_addr  = 32'h0400_0020;
      iomem_wstrb = 4'h0;
      @(negedge clk);
      iomem_valid = 1'b0;
      check("pre_rst_s_valid", 32'(s_valid), 32'h2);
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      check("midrst_s_valid", 32'(s_valid), 32'd0);
      check("midrst_iomem_ready", 32'(iomem_ready), 32'd0);
      check("midrst_iomem_rdata", iomem_rdata, 32'd0);
      check("midrst_s_addr", s_addr, 32'd0);
      check("midrst_err_count", 32'(err_count), 32'd0);
      check("midrst_err_addr", err_addr, 32'd0);
      resetn = 1'b1;
      m_cnt  = 0;
      m_addr = '0;
      pulses = 0;
      repeat (10) begin
         @(negedge clk);
         if (iomem_ready) pulses++;
         if (s_valid != '0) pulses++;
      end
      check("after_rst_no_activity", pulses, 0);

      // Normal access after reset recovery
      v = predict(32'h0500_0040, 4'h3, 32'hBEEF_0001, 2, '0,
                  {32'h0, 32'hABCD_0123, 64'h0}, 1'b0);
      run_txn(v);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
